// File: rtl/inst_fetcher_if.sv
// Fetch-stage bundle: memory request/response, redirect and decode-side queue handshake.
// The master modport is the fetcher; the slave modport is its environment (icache/decoder/branch unit).
interface inst_fetcher_if;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        flush_in;
    logic [31:0] flush_pc;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    modport master (
        output mem_req_valid, mem_req_addr, out_valid, out_inst, out_pc,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, flush_in, flush_pc, out_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, out_valid, out_inst, out_pc,
        output mem_req_ready, mem_resp_valid, mem_resp_data, flush_in, flush_pc, out_ready
    );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: single-outstanding word fetcher feeding a show-ahead {inst,pc} queue.
// Optional macro IFETCH_JAL_PREDICT_EN redirects the fetch PC through enqueued JAL instructions.
module inst_fetcher #(
    parameter int          QUEUE_ADDR_W = 3,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    inst_fetcher_if.master bus
);

    localparam int                      DEPTH     = 1 << QUEUE_ADDR_W;
    localparam logic [QUEUE_ADDR_W:0]   DEPTH_CNT = (QUEUE_ADDR_W + 1)'(DEPTH);
    localparam logic [QUEUE_ADDR_W:0]   CNT_ONE   = (QUEUE_ADDR_W + 1)'(1);
    localparam logic [QUEUE_ADDR_W-1:0] PTR_ONE   = QUEUE_ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t                  r_state;
    logic [31:0]             r_pc;
    logic                    r_drop;
    logic                    r_reqValid;
    logic [31:0]             r_reqAddr;
    logic [QUEUE_ADDR_W-1:0] r_head;
    logic [QUEUE_ADDR_W-1:0] r_tail;
    logic [QUEUE_ADDR_W:0]   r_count;
    logic [31:0]             r_qInst [DEPTH];
    logic [31:0]             r_qPc   [DEPTH];

    logic        w_space;
    logic        w_respTake;
    logic        w_enq;
    logic        w_deq;
    logic [31:0] w_pcSum;
    logic [31:0] w_nextPc;

    assign w_space    = (r_count < DEPTH_CNT);
    assign w_respTake = (r_state == WAIT) && bus.mem_resp_valid;
    assign w_enq      = w_respTake && !r_drop && !bus.flush_in;
    assign w_deq      = (r_count != '0) && bus.out_ready && !bus.flush_in;

`ifdef IFETCH_JAL_PREDICT_EN
    logic        w_isJal;
    logic [31:0] w_jalImm;

    assign w_isJal  = (bus.mem_resp_data[6:0] == 7'h6f);
    assign w_jalImm = {{11{bus.mem_resp_data[31]}}, bus.mem_resp_data[31],
                       bus.mem_resp_data[19:12], bus.mem_resp_data[20],
                       bus.mem_resp_data[30:21], 1'b0};
    assign w_pcSum  = r_pc + (w_isJal ? w_jalImm : 32'd4);
`else
    assign w_pcSum  = r_pc + 32'd4;
`endif

    // Low PC bits belong to whoever loaded the PC; sequential/JAL advance never touches them.
    assign w_nextPc = {w_pcSum[31:2], r_pc[1:0]};

    assign bus.mem_req_valid = r_reqValid;
    assign bus.mem_req_addr  = r_reqAddr;
    assign bus.out_valid     = (r_count != '0);
    assign bus.out_inst      = r_qInst[r_head];
    assign bus.out_pc        = r_qPc[r_head];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_drop     <= 1'b0;
            r_reqValid <= 1'b0;
            r_reqAddr  <= 32'h0;
        end else if (rdy_in) begin
            if (bus.flush_in) begin
                r_pc <= bus.flush_pc;
                case (r_state)
                    IDLE: r_state <= IDLE;
                    REQ: begin
                        r_reqValid <= 1'b0;
                        // An accepted request still owes us a response, so it must be swallowed.
                        if (bus.mem_req_ready) begin
                            r_state <= WAIT;
                            r_drop  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    WAIT: begin
                        if (bus.mem_resp_valid) begin
                            r_state <= IDLE;
                            r_drop  <= 1'b0;
                        end else begin
                            r_drop  <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_space) begin
                            r_reqValid <= 1'b1;
                            r_reqAddr  <= r_pc;
                            r_state    <= REQ;
                        end
                    end
                    REQ: begin
                        if (bus.mem_req_ready) begin
                            r_reqValid <= 1'b0;
                            r_state    <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.mem_resp_valid) begin
                            if (!r_drop) begin
                                r_pc <= w_nextPc;
                            end
                            r_drop  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_qInst[i] <= 32'h0;
                r_qPc[i]   <= 32'h0;
            end
        end else if (rdy_in) begin
            if (bus.flush_in) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_enq) begin
                    r_qInst[r_tail] <= bus.mem_resp_data;
                    r_qPc[r_tail]   <= r_pc;
                    r_tail          <= r_tail + PTR_ONE;
                end
                if (w_deq) begin
                    r_head <= r_head + PTR_ONE;
                end
                if (w_enq && !w_deq) begin
                    r_count <= r_count + CNT_ONE;
                end else if (!w_enq && w_deq) begin
                    r_count <= r_count - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Front-end fetch stage directly upstream of the instruction decoder.
- Keeps the fetch PC and issues one word-aligned fetch at a time to the memory/icache controller.
- Buffers returned words with their PCs in a show-ahead instruction queue, which the decode/issue stage drains.
- Redirects on a flush from the commit/branch unit.

Parameters:
- QUEUE_ADDR_W, 3, log2 of queue depth (8 entries).
- RESET_PC, 32'h0, fetch PC after reset.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; when low, all state holds and no handshakes complete
- mem_req_valid  output  1  fetch request, registered
- mem_req_addr  output  32  fetch address, registered
- mem_req_ready  input  1  controller accepts request this cycle
- mem_resp_valid  input  1  fetched word valid (one-cycle pulse)
- mem_resp_data  input  32  fetched instruction word
- flush_in  input  1  redirect; discard all in-flight and queued work
- flush_pc  input  32  redirect target
- out_valid  output  1  queue head valid
- out_inst  output  32  head instruction word
- out_pc  output  32  head instruction PC
- out_ready  input  1  decode consumes head this cycle

Behaviour:
- Reset values:
  - pc=RESET_PC, state=IDLE, queue empty, drop=0.
  - mem_req_valid=0, mem_req_addr=0, out_valid=0, out_inst=0, out_pc=0.
- Queue storage:
  - 2^QUEUE_ADDR_W entries of {inst,pc}.
  - head/tail pointers QUEUE_ADDR_W bits wide, wrap modulo depth.
  - Count is QUEUE_ADDR_W+1 bits.
  - out_* are driven from the head entry; out_valid = (count!=0).
- Dequeue when out_valid && out_ready. Enqueue on an accepted non-dropped response.
- Simultaneous enqueue and dequeue: count unchanged.
- FSM:
  - IDLE: if count < depth and no flush, then mem_req_valid<=1, mem_req_addr<=pc, go to REQ.
  - REQ: hold mem_req_valid/addr stable. On mem_req_ready, mem_req_valid<=0 and go to WAIT.
  - WAIT: on mem_resp_valid:
    - if drop=0, enqueue {mem_resp_data, pc} and set pc<=pc+4;
    - clear drop and go to IDLE.
- At most one outstanding request. The space check happens at issue, so the queue cannot overflow; a response always finds a free slot.
- Latency:
  - Request is visible 1 cycle after entering IDLE with space.
  - Enqueued word is visible on out_* the cycle after mem_resp_valid.
- Flush (highest priority; overrides enqueue/dequeue in the same cycle):
  - Queue cleared: head=tail=count=0. out_valid=0 from the next cycle.
  - pc<=flush_pc.
  - In REQ: mem_req_valid<=0 and go to IDLE. Request retraction before acceptance is legal.
  - In REQ with mem_req_ready in the same cycle: treat as accepted, go to WAIT with drop<=1.
  - In WAIT without a response: drop<=1 and stay in WAIT; the late response is discarded.
  - In WAIT with mem_resp_valid in the same cycle: discard the response and go to IDLE.
  - In IDLE: no request that cycle.
- PC arithmetic is modulo 2^32. pc bits [1:0] are never altered by the block.
- rdy_in low: freeze everything, including flush sampling. mem_req_valid keeps its value.
- Reset mid-operation: return to reset values. Any response arriving afterwards in IDLE is ignored, since responses are only accepted in WAIT.

Optional Feature:
- Macro: IFETCH_JAL_PREDICT_EN.
- With it defined, on a non-dropped enqueue whose word has opcode[6:0]==7'h6f:
  - next pc <= pc + sign-extended J-immediate {inst[31],inst[19:12],inst[20],inst[30:21],1'b0};
  - the JAL itself is still enqueued.
- Without it, pc always advances by 4.

Test Plan:
- Reset, rdy_in=1, mem_req_ready=1, response 2 cycles after acceptance with data 32'h00000013:
  - requests go to addresses 0,4,8 in order;
  - out_pc=0 then 4 with out_inst=32'h00000013.
- Hold out_ready=0 with immediate responses:
  - exactly 8 entries enqueued, then mem_req_valid stays 0;
  - one dequeue yields the next request at the next sequential address.
- Flush with flush_pc=32'h100 while in WAIT; response arrives 3 cycles later:
  - response not enqueued, out_valid=0;
  - next request address is 32'h100.
- flush_in coincident with mem_resp_valid and out_ready=1:
  - queue empties, no enqueue;
  - next request goes to flush_pc;
  - count never goes negative.
- With IFETCH_JAL_PREDICT_EN, pc=32'h10 returns 32'h0100006f (jal x0,+16):
  - entry pc=32'h10 is enqueued;
  - next request address is 32'h20.
  - Without the macro, the next request address is 32'h14.
- Toggle rdy_in=0 for 5 cycles mid-WAIT with no response:
  - all outputs and the queue are unchanged;
  - resumes correctly after rdy_in returns to 1.
